// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8 shared types and constants.
// Sizes, FSM state encoding and the default grant-hold limit.
package rr_arbiter8_pkg;

  localparam int ARB_N        = 8;
  localparam int ARB_IDX_W    = 3;
  localparam int ARB_HOLD_MAX = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter8_enc.sv
// arb_onehot_enc: 8-bit one-hot to 3-bit index encoder.
// Ports: oh (one-hot or zero in), idx (binary index out, 0 when oh=0).
module arb_onehot_enc
  import rr_arbiter8_pkg::*;
(
  input  logic [ARB_N-1:0]     oh,
  output logic [ARB_IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    unique case (1'b1)
      oh[0]:   idx = 3'd0;
      oh[1]:   idx = 3'd1;
      oh[2]:   idx = 3'd2;
      oh[3]:   idx = 3'd3;
      oh[4]:   idx = 3'd4;
      oh[5]:   idx = 3'd5;
      oh[6]:   idx = 3'd6;
      oh[7]:   idx = 3'd7;
      default: idx = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way locking round-robin arbiter with registered grant.
// Ports: clk, rst (sync, high), req[7:0], gnt[7:0], gnt_idx[2:0],
// gnt_valid, timeout (only with ARB_TIMEOUT_EN: grant revoke pulse).
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDX_W    = ARB_IDX_W
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int HOLD_MAX = ARB_HOLD_MAX
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  arb_state_t state, state_nxt;

  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] srch;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [N-1:0]     win_oh;
  logic [N-1:0]     gnt_nxt;
  logic             valid_nxt;
  logic             found;
  logic             owner_req;
  logic             to_hit;
  logic             rel;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX);
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             to_nxt;
`endif

  assign owner_req = req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  assign to_hit = (state == GRANT) && owner_req &&
                  (hold_cnt == CNT_W'(HOLD_MAX - 1));
`else
  assign to_hit = 1'b0;
`endif

  // A revoked grant behaves exactly like a voluntary release.
  assign rel  = (state == GRANT) && (!owner_req || to_hit);

  // Search starts just past the outgoing owner on release.
  assign srch = rel ? gnt_idx + IDX_W'(1) : ptr;

  always_comb begin
    win_oh = '0;
    found  = 1'b0;
    k      = '0;
    for (int i = 0; i < N; i++) begin
      k = srch + IDX_W'(i);
      if (!found && req[k]) begin
        win_oh[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  arb_onehot_enc u_enc (
    .oh  (win_oh),
    .idx (win_idx)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    valid_nxt = gnt_valid;
`ifdef ARB_TIMEOUT_EN
    hold_nxt  = hold_cnt;
    to_nxt    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          gnt_nxt   = win_oh;
          idx_nxt   = win_idx;
          valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_nxt  = '0;
`endif
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nxt = srch;
`ifdef ARB_TIMEOUT_EN
          to_nxt  = to_hit;
`endif
          if (found) begin
            gnt_nxt   = win_oh;
            idx_nxt   = win_idx;
`ifdef ARB_TIMEOUT_EN
            hold_nxt  = '0;
`endif
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            valid_nxt = 1'b0;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_nxt = hold_cnt + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
        gnt_nxt   = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= hold_nxt;
      timeout   <= to_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: scoreboard of expected grant state per edge.
// Also exercises the revoke path when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter8;

  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  always #5 clk = ~clk;

  rr_arbiter8 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    logic       t;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic [7:0] m_gnt = '0;
  logic [2:0] m_idx = '0;
  logic [2:0] m_ptr = '0;
  logic       m_v   = 1'b0;
  int         m_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input logic [7:0] r, input int s);
    for (int j = 0; j < 8; j++)
      if (r[(s + j) % 8]) return (s + j) % 8;
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_gnt = 8'h01 << w;
    m_idx = 3'(w);
    m_v   = 1'b1;
    m_cnt = 0;
  endtask

  task automatic model(input logic r, input logic [7:0] q);
    exp_t e;
    int   w;
    logic to;
    to = 1'b0;
    if (r) begin
      m_gnt = '0; m_idx = '0; m_v = 1'b0;
      m_ptr = '0; m_cnt = 0;
    end else if (!m_v) begin
      w = first_from(q, int'(m_ptr));
      if (w >= 0) m_grant(w);
    end else begin
`ifdef ARB_TIMEOUT_EN
      to = q[m_idx] && (m_cnt == HOLD - 1);
`endif
      if (!q[m_idx] || to) begin
        m_ptr = m_idx + 3'd1;
        w = first_from(q, int'(m_ptr));
        if (w >= 0) m_grant(w);
        else begin
          m_gnt = '0;
          m_v   = 1'b0;
        end
      end else begin
        m_cnt++;
      end
    end
    e = '{g: m_gnt, i: m_idx, v: m_v, t: to};
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic [7:0] q);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = q;
    model(r, q);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sbq_empty got 0 want 1");
    end else begin
      e = sbq.pop_front();
      chk("gnt", 32'(gnt), 32'(e.g));
      chk("idx", 32'(gnt_idx), 32'(e.i));
      chk("valid", 32'(gnt_valid), 32'(e.v));
`ifdef ARB_TIMEOUT_EN
      chk("timeout", 32'(timeout), 32'(e.t));
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;

    // reset with all requesting
    cyc(1'b1, 8'hFF);
    cyc(1'b1, 8'hFF);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'h0);
    cyc(1'b0, 8'hFF);
    chk("first_idx", 32'(gnt_idx), 32'd0);
    cyc(1'b0, 8'h00);

    // single request held, then released
    cyc(1'b0, 8'h04);
    chk("single_gnt", 32'(gnt), 32'h04);
    chk("single_idx", 32'(gnt_idx), 32'd2);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h04);
    chk("hold_idx", 32'(gnt_idx), 32'd2);
    cyc(1'b0, 8'h00);
    chk("drop_valid", 32'(gnt_valid), 32'h0);
    chk("drop_gnt", 32'(gnt), 32'h0);
    cyc(1'b0, 8'h09);
    chk("ptr3_idx", 32'(gnt_idx), 32'd3);
    cyc(1'b0, 8'h00);

    // rotation with back-to-back grants
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'hFF);
    chk("rot_0", 32'(gnt_idx), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 8'hFF & ~(8'h01 << ((i - 1) % 8)));
      chk("rot_idx", 32'(gnt_idx), 32'(i % 8));
      chk("rot_valid", 32'(gnt_valid), 32'h1);
    end
    cyc(1'b0, 8'h00);

    // wrap from ptr 6 to idx 0, then to idx 5
    cyc(1'b0, 8'h20);
    chk("wrap_5", 32'(gnt_idx), 32'd5);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h21);
    chk("wrap_0", 32'(gnt_idx), 32'd0);
    cyc(1'b0, 8'h20);
    chk("wrap_back5", 32'(gnt_idx), 32'd5);
    cyc(1'b0, 8'h00);

    // reset while a grant is active
    cyc(1'b0, 8'h10);
    chk("mid_4", 32'(gnt_idx), 32'd4);
    cyc(1'b1, 8'h10);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    cyc(1'b0, 8'h12);
    chk("mid_idx1", 32'(gnt_idx), 32'd1);
    cyc(1'b0, 8'h00);

    // random traffic against the model
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 40) == 0), 8'($urandom));

`ifdef ARB_TIMEOUT_EN
    begin
      int hit;
      hit = -1;
      cyc(1'b1, 8'h00);
      cyc(1'b0, 8'h08);
      chk("to_first", 32'(gnt_idx), 32'd3);
      for (int i = 0; i < 40; i++) begin
        cyc(1'b0, 8'h48);
        if (timeout && hit < 0) begin
          hit = i;
          chk("to_next", 32'(gnt_idx), 32'd6);
        end
      end
      chk("to_edge", 32'(hit), 32'd15);
      cyc(1'b0, 8'h00);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
